// File: rtl/wb_rr_arbiter.sv
// Registered round-robin arbiter: NM Wishbone masters share one slave bus.
// A watchdog ends a strobe the slave leaves stalled by erroring the owner.
module wb_rr_arbiter #(
    parameter  int AW      = 30,
    parameter  int DW      = 32,
    parameter  int NM      = 2,
    parameter  int TIMEOUT = 255,
    localparam int SW      = DW / 8,
    localparam int IW      = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_reset_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*SW-1:0] m_sel_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [DW-1:0]    m_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [SW-1:0]    s_sel_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic [DW-1:0]    s_dat_i,
    output logic [NM-1:0]    grant_o
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] own_q, own_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NM-1:0] grant_q, grant_d;

    logic [IW-1:0] win;
    logic          any_req;
    logic          own_cyc;
    logic          stall;
    int            j;

    // Scan starting just after the previous winner so every master gets a turn.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 1; i <= NM; i++) begin
            j = (int'(last_q) + i) % NM;
            if (!any_req && m_cyc_i[IW'(j)]) begin
                any_req = 1'b1;
                win     = IW'(j);
            end
        end
    end

    assign own_cyc = m_cyc_i[own_q];
    assign stall   = s_stb_o & ~s_ack_i & ~s_err_i;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        case (state_q)
            S_GRANT: begin
                s_cyc_o = own_cyc;
                s_stb_o = own_cyc & m_stb_i[own_q];
                s_we_o  = m_we_i[own_q];
                s_adr_o = m_adr_i[int'(own_q) * AW +: AW];
                s_dat_o = m_dat_i[int'(own_q) * DW +: DW];
                s_sel_o = m_sel_i[int'(own_q) * SW +: SW];
                m_ack_o[own_q] = s_ack_i & own_cyc;
                m_err_o[own_q] = s_err_i & own_cyc;
            end
            S_ABORT: m_err_o[own_q] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d      = S_GRANT;
                    own_d        = win;
                    last_d       = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                end
            end
            S_GRANT: begin
                if (!own_cyc) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (TIMEOUT > 0 && stall) begin
                    // An ack or err in the expiry cycle clears stall, so it wins.
                    if (cnt_q == CNT_LAST) state_d = S_ABORT;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_i) begin
            state_q <= S_IDLE;
            own_q   <= '0;
            last_q  <= IW'(NM - 1);
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: a transaction-level reference model
// predicts every cycle's outputs; a separate monitor pops and compares them.
module tb_wb_rr_arbiter;
    localparam int NM = 3, AW = 30, DW = 32, SW = 4, TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, grant;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*SW-1:0] m_sel;
    logic [DW-1:0]    m_rdat, s_dat_o, s_dat;
    logic             s_cyc, s_stb, s_we, s_ack, s_err;
    logic [AW-1:0]    s_adr;
    logic [SW-1:0]    s_sel;

    wb_rr_arbiter #(.AW(AW), .DW(DW), .NM(NM), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_reset_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr),
        .m_dat_i(m_dat), .m_sel_i(m_sel), .m_ack_o(m_ack), .m_err_o(m_err),
        .m_dat_o(m_rdat), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_ack_i(s_ack),
        .s_err_i(s_err), .s_dat_i(s_dat), .grant_o(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NM-1:0] grant, ack, err;
        logic          cyc, stb, we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat, mdat;
        logic [SW-1:0] sel;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0, miscompares = 0, busy_timeouts = 0;
    bit   rec_on = 0, fin_req = 0, fin_done = 0;
    logic [NM-1:0] gq[$];

    // Master behaviour: each master runs bursts of beats, then drops cyc.
    bit            act[NM];
    int            beats[NM], gap[NM], budget[NM];
    logic [AW-1:0] cur_adr[NM], cfg_adr[NM];
    logic [DW-1:0] cur_dat[NM], cfg_dat[NM];
    logic [SW-1:0] cur_sel[NM], cfg_sel[NM];
    bit            cur_we[NM], cfg_we[NM];
    int            cfg_beats[NM];
    bit            cfg_rand = 0, noise = 0;
    int            req_pct = 100, gap_cfg = 1, hole_pct = 0;

    // Slave behaviour: ack/err after slat stalled strobe cycles, plus strays.
    int slat = 1, srun = 0, stray_pct = 0, err_pct = 0;
    bit rand_lat = 0, fixed_dat = 1;

    // Reference: who owns the bus (-1 none), whether it is being aborted,
    // the last winner, and how many consecutive strobe cycles went unanswered.
    int owner = -1, last = NM - 1, stall_run = 0;
    bit aborting = 0;

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, 2));
        if (r < 9) return int'($urandom_range(3, 6));
        return int'($urandom_range(9, 12));
    endfunction

    function automatic bit pred_stb();
        return owner >= 0 && !aborting && m_cyc[owner] && m_stb[owner];
    endfunction

    task automatic drive_masters();
        for (int k = 0; k < NM; k++) begin
            if (!act[k]) begin
                if (gap[k] > 0) gap[k]--;
                else if (budget[k] > 0 && int'($urandom_range(0, 99)) < req_pct) begin
                    act[k] = 1;
                    budget[k]--;
                    if (cfg_rand) begin
                        cur_adr[k] = AW'($urandom);
                        cur_dat[k] = $urandom;
                        cur_sel[k] = SW'($urandom_range(1, 15));
                        cur_we[k]  = 1'($urandom_range(0, 1));
                        beats[k]   = int'($urandom_range(1, 4));
                    end else begin
                        cur_adr[k] = cfg_adr[k];
                        cur_dat[k] = cfg_dat[k];
                        cur_sel[k] = cfg_sel[k];
                        cur_we[k]  = cfg_we[k];
                        beats[k]   = cfg_beats[k];
                    end
                end
            end
            m_cyc[k] = act[k];
            if (act[k]) m_stb[k] = int'($urandom_range(0, 99)) >= hole_pct;
            else        m_stb[k] = noise && ($urandom_range(0, 1) == 1);
            m_we[k] = cur_we[k];
            m_adr[k*AW +: AW] = cur_adr[k];
            m_dat[k*DW +: DW] = cur_dat[k];
            m_sel[k*SW +: SW] = cur_sel[k];
        end
    endtask

    task automatic drive_slave();
        s_ack = 0;
        s_err = 0;
        s_dat = fixed_dat ? 32'h1234_5678 : $urandom;
        if (pred_stb()) begin
            if (srun >= slat) begin
                if (int'($urandom_range(0, 99)) < err_pct) s_err = 1;
                else                                       s_ack = 1;
                srun = 0;
                if (rand_lat) slat = pick_lat();
            end else srun++;
        end else begin
            srun = 0;
            if (int'($urandom_range(0, 99)) < stray_pct) begin
                if ($urandom_range(0, 3) == 0) s_err = 1;
                else                           s_ack = 1;
            end
        end
    endtask

    task automatic predict(output exp_t e);
        e = '{default: '0};
        e.mdat = s_dat;
        if (owner >= 0) begin
            e.grant = NM'(1) << owner;
            if (aborting) e.err = NM'(1) << owner;
            else begin
                e.cyc = m_cyc[owner];
                e.stb = m_cyc[owner] & m_stb[owner];
                e.we  = m_we[owner];
                e.adr = m_adr[owner*AW +: AW];
                e.dat = m_dat[owner*DW +: DW];
                e.sel = m_sel[owner*SW +: SW];
                if (e.cyc && s_ack) e.ack = NM'(1) << owner;
                if (e.cyc && s_err) e.err = NM'(1) << owner;
            end
        end
        if (!rst_n) begin
            owner = -1; aborting = 0; last = NM - 1; stall_run = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= NM; k++)
                if (owner < 0 && m_cyc[(last + k) % NM]) owner = (last + k) % NM;
            if (owner >= 0) last = owner;
        end else if (aborting) begin
            owner = -1; aborting = 0;
        end else if (!m_cyc[owner]) begin
            owner = -1; stall_run = 0;
        end else if (m_stb[owner] && !s_ack && !s_err) begin
            stall_run++;
            if (stall_run == TIMEOUT) begin aborting = 1; stall_run = 0; end
        end else stall_run = 0;
    endtask

    task automatic cycle();
        exp_t e;
        drive_masters();
        drive_slave();
        predict(e);
        expq.push_back(e);
        for (int k = 0; k < NM; k++) begin
            if (act[k] && (e.ack[k] || e.err[k])) begin
                beats[k]--;
                cur_adr[k]++;
                cur_dat[k]++;
                if (beats[k] == 0) begin
                    act[k] = 0;
                    gap[k] = gap_cfg + (cfg_rand ? int'($urandom_range(0, 3)) : 0);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_done();
        for (int k = 0; k < NM; k++) if (act[k] || budget[k] > 0) return 0;
        return 1;
    endfunction

    task automatic run_until_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!(all_done() && owner < 0) && n < max_cyc) begin cycle(); n++; end
        if (n >= max_cyc) begin
            busy_timeouts++;
            $display("FAIL %s_timeout: bus still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic set_master(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s, input bit w, input int nb);
        cfg_adr[k] = a; cfg_dat[k] = d; cfg_sel[k] = s; cfg_we[k] = w; cfg_beats[k] = nb;
    endtask

    // Monitor: compares DUT outputs with the oldest prediction each falling edge.
    initial begin
        exp_t me;
        logic [NM-1:0] prev_g, want;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                me = expq.pop_front();
                vectors++;
                if (grant !== me.grant || m_ack !== me.ack || m_err !== me.err ||
                    s_cyc !== me.cyc || s_stb !== me.stb || s_we !== me.we ||
                    s_adr !== me.adr || s_dat_o !== me.dat || s_sel !== me.sel ||
                    m_rdat !== me.mdat) begin
                    miscompares++;
                    $display("FAIL bus_cycle @%0t: got grant=%b ack=%b err=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b mdat=%h; want grant=%b ack=%b err=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b mdat=%h",
                             $time, grant, m_ack, m_err, s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel, m_rdat,
                             me.grant, me.ack, me.err, me.cyc, me.stb, me.we, me.adr, me.dat, me.sel, me.mdat);
                end
            end
            if (rec_on && grant != '0 && prev_g == '0) gq.push_back(grant);
            prev_g = grant;
            if (fin_req && !fin_done) begin
                vectors++;
                if (gq.size() != 8) begin
                    miscompares++;
                    $display("FAIL rr_tenures: got %0d tenures, want 8", gq.size());
                end
                for (int i = 0; i < gq.size() && i < 8; i++) begin
                    want = (i % 2 == 0) ? NM'(1) : NM'(2);
                    vectors++;
                    if (gq[i] !== want) begin
                        miscompares++;
                        $display("FAIL rr_order[%0d]: got %b, want %b", i, gq[i], want);
                    end
                end
                vectors++;
                if (busy_timeouts != 0) miscompares++;
                fin_done = 1;
            end
        end
    end

    initial begin
        rst_n = 0; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 0; s_err = 0; s_dat = '0;
        for (int k = 0; k < NM; k++) begin
            act[k] = 0; beats[k] = 0; gap[k] = 0; budget[k] = 0;
            cur_adr[k] = '0; cur_dat[k] = '0; cur_sel[k] = '0; cur_we[k] = 0;
            set_master(k, '0, '0, 4'hF, 0, 1);
        end
        repeat (2) @(posedge clk);
        #1;
        repeat (2) cycle();
        rst_n = 1;

        // Single read by master 0, slave answers one cycle after the strobe.
        set_master(0, 30'h0400_0000, 32'h0, 4'hF, 0, 1);
        budget[0] = 1; slat = 1;
        run_until_idle(40, "single_read");
        repeat (2) cycle();

        // Masters 0 and 1 request together from reset: tenures must alternate.
        fixed_dat = 0;
        rst_n = 0; repeat (2) cycle(); rst_n = 1;
        set_master(1, 30'h0000_0100, 32'h0, 4'hF, 0, 1);
        rec_on = 1; budget[0] = 4; budget[1] = 4;
        run_until_idle(200, "alternate");
        rec_on = 0;
        repeat (2) cycle();

        // Master 1 locks the bus for a 3-beat write while master 0 waits.
        set_master(1, 30'h0000_0200, 32'hA5A5_0001, 4'b0011, 1, 3);
        slat = 0; budget[1] = 1;
        cycle();
        budget[0] = 1;
        run_until_idle(60, "burst_lock");
        repeat (2) cycle();

        // Slave never answers: watchdog abort, stray acks afterwards ignored.
        slat = 1000; stray_pct = 100; budget[0] = 1;
        run_until_idle(60, "watchdog");
        repeat (4) cycle();
        stray_pct = 0;

        // Slave error on a write goes straight back to the owner.
        set_master(0, 30'h0000_0300, 32'hDEAD_BEEF, 4'hF, 1, 1);
        slat = 0; err_pct = 100; budget[0] = 1;
        run_until_idle(40, "slave_err");
        err_pct = 0;
        repeat (2) cycle();

        // Reset pulse while master 0 owns the bus with the strobe up.
        slat = 3; budget[0] = 1; budget[1] = 1;
        set_master(0, 30'h0000_0400, 32'h0, 4'hF, 0, 2);
        set_master(1, 30'h0000_0500, 32'h0, 4'hF, 0, 2);
        for (int n = 0; n < 50 && !(owner == 0 && !aborting && act[0]); n++) cycle();
        rst_n = 0; cycle(); rst_n = 1;
        run_until_idle(100, "reset_mid");
        repeat (2) cycle();

        // Randomised traffic on all masters with wait states, errors and strays.
        cfg_rand = 1; noise = 1; req_pct = 30; hole_pct = 15;
        rand_lat = 1; slat = pick_lat(); err_pct = 10; stray_pct = 10;
        for (int k = 0; k < NM; k++) budget[k] = 1000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 599) == 0) rst_n = 0;
            cycle();
            rst_n = 1;
        end
        for (int k = 0; k < NM; k++) budget[k] = 0;
        hole_pct = 0;
        run_until_idle(300, "random_drain");
        repeat (3) cycle();

        fin_req = 1;
        for (int i = 0; i < 20 && !fin_done; i++) @(posedge clk);
        if (!fin_done) begin
            $display("FAIL monitor_stuck: final checks never ran");
            $fatal(1, "monitor did not complete");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
